// File: rtl/pwm_deadtime_gen.sv
// pwm_deadtime_gen
//   Center-aligned PWM with complementary dead-time gate drive for one
//   half-bridge leg. A symmetric up/down carrier is compared against a
//   compare value. The compare value is a clamped copy of duty_in, taken
//   only at the carrier valley. The raw compare result drives a small FSM.
//   The FSM inserts DEADTIME both-off clocks at every hand-over between the
//   high-side and low-side devices. A synchronized external fault latches
//   and parks both devices off until it is cleared, and the leg restarts
//   only at the next valley.
//
// Ports
//   clk            system clock
//   rst            asynchronous active-low reset
//   en             modulator enable; 0 holds the carrier at 0 and idles the FSM
//   duty_in        signed duty command, clamped to [0, PERIOD] every clock
//   fault          asynchronous active-high fault input
//   fault_clr      synchronous request to clear the latched fault
//   pwm_h / pwm_l  registered high-side / low-side gate drives
//   carrier        current carrier count
//   sync           one-clock pulse following each valley (compare reload)
//   fault_latched  sticky fault flag
//
// FSM states
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | both devices off; waits for a valley sync with no fault
//   S_LOW    | low-side device on
//   S_DT_LH  | dead time, low-side already off, high-side not yet on
//   S_HIGH   | high-side device on
//   S_DT_HL  | dead time, high-side already off, low-side not yet on

module pwm_deadtime_gen #(
   parameter int DATA_W   = 32,
   parameter int CNT_W    = 16,
   parameter int PERIOD   = 1000,
   parameter int DEADTIME = 20
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] duty_in,
   input  logic                     fault,
   input  logic                     fault_clr,
   output logic                     pwm_h,
   output logic                     pwm_l,
   output logic [CNT_W-1:0]         carrier,
   output logic                     sync,
   output logic                     fault_latched
);

   localparam logic [CNT_W-1:0]         PERIOD_C  = CNT_W'(PERIOD);
   localparam logic signed [DATA_W-1:0] PERIOD_SD = DATA_W'(PERIOD);

   localparam bit DT_EN     = (DEADTIME > 0);
   localparam int DT_W      = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
   localparam int DT_LAST_I = (DEADTIME > 0) ? DEADTIME - 1 : 0;
   localparam logic [DT_W-1:0] DT_LAST = DT_LAST_I[DT_W-1:0];

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOW   = 3'd1,
      S_DT_LH = 3'd2,
      S_HIGH  = 3'd3,
      S_DT_HL = 3'd4
   } state_t;

   logic [CNT_W-1:0] carrier_q, carrier_d;
   logic             dir_up_q, dir_up_d;
   logic [CNT_W-1:0] cmp_q, cmp_d;
   logic             sync_q, sync_d;
   logic             fault_meta_q;
   logic             fault_sync_q;
   logic             fault_latched_q, fault_latched_d;
   state_t           state_q, state_d;
   logic [DT_W-1:0]  dt_cnt_q, dt_cnt_d;
   logic             pwm_h_q, pwm_h_d;
   logic             pwm_l_q, pwm_l_d;

   logic             valley;
   logic [CNT_W-1:0] duty_clamped;
   logic             raw;

   // Carrier: the direction flips on the clock that sits at a turning point,
   // so PERIOD and 0 are each visited once per 2*PERIOD clocks.
   always_comb begin
      dir_up_d  = dir_up_q;
      carrier_d = carrier_q;
      if (!en) begin
         dir_up_d  = 1'b1;
         carrier_d = '0;
      end else begin
         if (carrier_q == PERIOD_C) begin
            dir_up_d = 1'b0;
         end else if (carrier_q == '0) begin
            dir_up_d = 1'b1;
         end
         carrier_d = dir_up_d ? carrier_q + CNT_W'(1) : carrier_q - CNT_W'(1);
      end
   end

   always_comb begin
      duty_clamped = duty_in[CNT_W-1:0];
      if (duty_in[DATA_W-1]) begin
         duty_clamped = '0;
      end else if (duty_in > PERIOD_SD) begin
         duty_clamped = PERIOD_C;
      end
   end

   assign valley = en && (carrier_q == '0);

   // The compare value only moves at the valley, so a mid-period command
   // change cannot reshape the pulse already in progress.
   always_comb begin
      cmp_d  = valley ? duty_clamped : cmp_q;
      sync_d = valley;
   end

   // Full scale stays on through the peak clock as well.
   assign raw = (cmp_q == PERIOD_C) || (carrier_q < cmp_q);

   // A synchronized fault outranks a clear in the same clock.
   always_comb begin
      fault_latched_d = fault_latched_q;
      if (fault_sync_q) begin
         fault_latched_d = 1'b1;
      end else if (fault_clr) begin
         fault_latched_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         carrier_q       <= '0;
         dir_up_q        <= 1'b1;
         cmp_q           <= '0;
         sync_q          <= 1'b0;
         fault_meta_q    <= 1'b0;
         fault_sync_q    <= 1'b0;
         fault_latched_q <= 1'b0;
      end else begin
         carrier_q       <= carrier_d;
         dir_up_q        <= dir_up_d;
         cmp_q           <= cmp_d;
         sync_q          <= sync_d;
         fault_meta_q    <= fault;
         fault_sync_q    <= fault_meta_q;
         fault_latched_q <= fault_latched_d;
      end
   end

   // FSM state register. The gate drives are flops fed from the next state,
   // so they follow state_q without any decode glitches.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         dt_cnt_q <= '0;
         pwm_h_q  <= 1'b0;
         pwm_l_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         dt_cnt_q <= dt_cnt_d;
         pwm_h_q  <= pwm_h_d;
         pwm_l_q  <= pwm_l_d;
      end
   end

   // FSM next state. A raw edge that reverts inside the dead-time window
   // returns to the device that was already on, so pulses shorter than
   // DEADTIME never reach the opposite device.
   always_comb begin
      state_d  = state_q;
      dt_cnt_d = dt_cnt_q;
      if (!en || fault_sync_q || fault_latched_q) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (sync_q) begin
                  state_d = S_LOW;
               end
            end
            S_LOW: begin
               if (raw) begin
                  if (DT_EN) begin
                     state_d  = S_DT_LH;
                     dt_cnt_d = '0;
                  end else begin
                     state_d = S_HIGH;
                  end
               end
            end
            S_DT_LH: begin
               if (!raw) begin
                  state_d = S_LOW;
               end else if (dt_cnt_q == DT_LAST) begin
                  state_d = S_HIGH;
               end else begin
                  dt_cnt_d = dt_cnt_q + DT_W'(1);
               end
            end
            S_HIGH: begin
               if (!raw) begin
                  if (DT_EN) begin
                     state_d  = S_DT_HL;
                     dt_cnt_d = '0;
                  end else begin
                     state_d = S_LOW;
                  end
               end
            end
            S_DT_HL: begin
               if (raw) begin
                  state_d = S_HIGH;
               end else if (dt_cnt_q == DT_LAST) begin
                  state_d = S_LOW;
               end else begin
                  dt_cnt_d = dt_cnt_q + DT_W'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // FSM outputs: one-hot decode, so both drives can never be on together.
   always_comb begin
      pwm_h_d = (state_d == S_HIGH);
      pwm_l_d = (state_d == S_LOW);
   end

   assign pwm_h         = pwm_h_q;
   assign pwm_l         = pwm_l_q;
   assign carrier       = carrier_q;
   assign sync          = sync_q;
   assign fault_latched = fault_latched_q;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Bench for pwm_deadtime_gen with PERIOD=100 and DEADTIME=5.
// A "window" runs from one sync pulse up to the next sync pulse, not
// including it. The monitor measures each window and compares it with any
// expectation that the stimulus queued for that window index.
module tb_pwm_deadtime_gen;

   localparam int DATA_W   = 32;
   localparam int CNT_W    = 16;
   localparam int PERIOD   = 100;
   localparam int DEADTIME = 5;

   logic                     clk;
   logic                     rst;
   logic                     en;
   logic signed [DATA_W-1:0] duty_in;
   logic                     fault;
   logic                     fault_clr;
   logic                     pwm_h;
   logic                     pwm_l;
   logic [CNT_W-1:0]         carrier;
   logic                     sync;
   logic                     fault_latched;

   pwm_deadtime_gen #(
      .DATA_W  (DATA_W),
      .CNT_W   (CNT_W),
      .PERIOD  (PERIOD),
      .DEADTIME(DEADTIME)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .duty_in      (duty_in),
      .fault        (fault),
      .fault_clr    (fault_clr),
      .pwm_h        (pwm_h),
      .pwm_l        (pwm_l),
      .carrier      (carrier),
      .sync         (sync),
      .fault_latched(fault_latched)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int win;
      int clocks;
      int h;
      int l;
      int low;
   } exp_t;

   exp_t exp_q[$];

   int total = 0;
   int bad   = 0;

   int win_idx   = 0;
   bit win_open  = 1'b0;
   int m_clocks, m_h, m_l, m_low;
   int ovl_total = 0;

   function automatic void chk(string name, int act, int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endfunction

   task automatic abort_run(string what);
      total++;
      bad++;
      $display("FAIL %s timeout", what);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   endtask

   // Monitor: samples on the falling edge and closes a window at each sync.
   always @(negedge clk) begin
      if (pwm_h && pwm_l) ovl_total++;
      if (sync) begin
         if (win_open) begin
            while (exp_q.size() > 0 && exp_q[0].win < win_idx) begin
               chk($sformatf("win%0d_missed", exp_q[0].win), 0, 1);
               void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].win == win_idx) begin
               exp_t e;
               e = exp_q.pop_front();
               chk($sformatf("win%0d_clocks", e.win), m_clocks, e.clocks);
               chk($sformatf("win%0d_pwm_h", e.win), m_h, e.h);
               chk($sformatf("win%0d_pwm_l", e.win), m_l, e.l);
               chk($sformatf("win%0d_both_low", e.win), m_low, e.low);
            end
         end
         win_idx++;
         win_open = 1'b1;
         m_clocks = 0;
         m_h      = 0;
         m_l      = 0;
         m_low    = 0;
      end
      if (win_open) begin
         m_clocks++;
         if (pwm_h) m_h++;
         if (pwm_l) m_l++;
         if (!pwm_h && !pwm_l) m_low++;
      end
   end

   task automatic push_exp(int win, int h, int l, int low);
      exp_t e;
      e.win    = win;
      e.clocks = 2 * PERIOD;
      e.h      = h;
      e.l      = l;
      e.low    = low;
      exp_q.push_back(e);
   endtask

   // Returns just after the falling edge of a sync cycle. act counts the
   // cycles in which either drive was on while waiting, sync cycle included.
   task automatic wait_sync(output int idx, output int act);
      act = 0;
      idx = -1;
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         #1;
         if (pwm_h || pwm_l) act++;
         if (sync) begin
            idx = win_idx;
            return;
         end
      end
      abort_run("sync_wait");
   endtask

   task automatic run_until(int target, output int idx);
      int act;
      idx = -1;
      for (int n = 0; n < 40; n++) begin
         wait_sync(idx, act);
         if (idx >= target) return;
      end
      abort_run("window_wait");
   endtask

   task automatic wait_pwm_h();
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         #1;
         if (pwm_h) return;
      end
      abort_run("pwm_h_wait");
   endtask

   task automatic cycles(int n);
      for (int k = 0; k < n; k++) @(negedge clk);
      #1;
   endtask

   // Applies a new duty in a sync cycle; the next window is the transition
   // and the two windows after that are checked as steady state.
   task automatic duty_phase(int duty, int h, int l, int low, inout int cur);
      duty_in = duty;
      push_exp(cur + 2, h, l, low);
      push_exp(cur + 3, h, l, low);
      run_until(cur + 4, cur);
   endtask

   initial begin
      int cur;
      int act;

      rst       = 1'b0;
      en        = 1'b0;
      duty_in   = '0;
      fault     = 1'b0;
      fault_clr = 1'b0;
      cycles(3);
      chk("rst_pwm_h", pwm_h, 0);
      chk("rst_pwm_l", pwm_l, 0);
      chk("rst_sync", sync, 0);
      chk("rst_fault_latched", fault_latched, 0);
      chk("rst_carrier", carrier, 0);

      rst = 1'b1;
      cycles(3);
      chk("dis_carrier", carrier, 0);
      chk("dis_pwm_l", pwm_l, 0);

      // duty 50: raw on for 99 clocks, pwm_h 99-5=94, pwm_l 200-99-5=96,
      // and two 5-clock both-off gaps per window
      en      = 1'b1;
      duty_in = 50;
      wait_sync(cur, act);
      push_exp(cur + 1, 94, 96, 10);
      push_exp(cur + 2, 94, 96, 10);
      run_until(cur + 3, cur);

      // 50 -> 80 with the carrier at 30 and counting up: this window keeps 94,
      // the next gives 2*80-1-5=154 high, 200-159-5=36 low
      cycles(29);
      duty_in = 80;
      push_exp(cur, 94, 96, 10);
      push_exp(cur + 1, 154, 36, 10);
      run_until(cur + 2, cur);

      duty_phase(-7, 0, 200, 0, cur);   // clamps to 0: low side permanently on
      duty_phase(250, 200, 0, 0, cur);  // clamps to PERIOD: high side permanently on
      duty_phase(2, 0, 197, 3, cur);    // 3-clock raw pulse swallowed by dead time
      duty_phase(50, 94, 96, 10, cur);

      // one-clock fault pulse while the high side is on
      wait_pwm_h();
      fault = 1'b1;
      cycles(1);
      fault = 1'b0;
      cycles(2);
      chk("flt_pwm_h", pwm_h, 0);
      chk("flt_pwm_l", pwm_l, 0);
      chk("flt_latched", fault_latched, 1);

      // a clear request while the fault is still asserted has no effect
      fault = 1'b1;
      cycles(3);
      fault_clr = 1'b1;
      cycles(1);
      fault_clr = 1'b0;
      cycles(2);
      chk("flt_held_latched", fault_latched, 1);
      fault = 1'b0;
      cycles(4);
      chk("flt_clr_ignored", fault_latched, 1);

      // valley syncs keep coming, but the leg stays parked while latched
      wait_sync(cur, act);
      chk("flt_parked_drive", act, 0);
      cycles(5);
      fault_clr = 1'b1;
      cycles(1);
      fault_clr = 1'b0;
      chk("flt_cleared", fault_latched, 0);
      chk("flt_cleared_pwm_l", pwm_l, 0);

      // nothing switches until the next sync, then the low side comes on
      wait_sync(cur, act);
      chk("resume_wait_drive", act, 0);
      cycles(1);
      chk("resume_pwm_l", pwm_l, 1);
      chk("resume_pwm_h", pwm_h, 0);
      push_exp(cur + 1, 94, 96, 10);
      run_until(cur + 2, cur);

      // asynchronous reset between clock edges while the high side is on
      wait_pwm_h();
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_pwm_h", pwm_h, 0);
      chk("arst_pwm_l", pwm_l, 0);
      chk("arst_sync", sync, 0);
      chk("arst_fault_latched", fault_latched, 0);
      chk("arst_carrier", carrier, 0);
      cycles(3);
      rst = 1'b1;
      cycles(2);

      chk("pending_expectations", exp_q.size(), 0);
      chk("overlap_cycles", ovl_total, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pwm_deadtime_gen.md
Name: pwm_deadtime_gen

Overview:
- Converts the limited inner-loop controller output (32-bit signed duty command) into a complementary high-side/low-side gate-drive pair.
- Uses a center-aligned up/down carrier, valley-synchronous duty update, programmable dead time and latched fault shutdown.
- Sits directly downstream of the second signal limiter.
- Replaces the bare comparator PWM path for driving a half-bridge.

Parameters:
- DATA_W, 32, width of the signed duty command input
- CNT_W, 16, carrier counter width
- PERIOD, 1000, carrier peak count; carrier period is 2*PERIOD clocks; must be < 2^CNT_W
- DEADTIME, 20, dead-time in clocks inserted at every output transition; 0 disables

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- en  in  1  modulator enable
- duty_in  in  DATA_W  signed duty command, sampled every clock
- fault  in  1  external fault, asynchronous, active-high
- fault_clr  in  1  fault clear request, synchronous
- pwm_h  out  1  high-side gate drive
- pwm_l  out  1  low-side gate drive
- carrier  out  CNT_W  current carrier count
- sync  out  1  one-clock pulse at carrier valley
- fault_latched  out  1  sticky fault flag

Behaviour:
- Reset (rst=0, asynchronous):
  - pwm_h=0, pwm_l=0, sync=0, fault_latched=0.
  - carrier=0, direction=up, cmp=0, FSM=S_IDLE.
  - Takes effect immediately, including mid-pulse.
- Carrier:
  - Counts 0,1,…,PERIOD,PERIOD-1,…,1,0,… and turns at PERIOD and at 0.
  - en=0: carrier held at 0, direction up, FSM forced to S_IDLE.
- Duty clamp, every clock:
  - dc = 0 if duty_in < 0 (signed compare).
  - dc = PERIOD if duty_in > PERIOD.
  - Otherwise dc = duty_in[CNT_W-1:0].
- Shadow load:
  - cmp <= dc only on clocks where carrier==0 and en=1.
  - sync=1 on those same clocks, registered.
  - Mid-period duty changes never affect the current period.
- Raw compare:
  - raw = 1 if cmp==PERIOD, else raw = (carrier < cmp).
  - raw high time per period = 2*cmp-1 clocks (cmp>0); 0 for cmp=0; 2*PERIOD for cmp=PERIOD.
- Dead-time FSM (registered outputs, 1-clock latency from raw); states with outputs (pwm_h, pwm_l):
  - S_IDLE (0,0): leaves to S_LOW on sync when en=1 and fault_latched=0.
  - S_LOW (0,1): raw=1 → S_DT_LH, dt_cnt=0.
  - S_DT_LH (0,0): raw=0 → S_LOW; dt_cnt==DEADTIME-1 → S_HIGH; else dt_cnt++.
  - S_HIGH (1,0): raw=0 → S_DT_HL, dt_cnt=0.
  - S_DT_HL (0,0): raw=1 → S_HIGH; dt_cnt==DEADTIME-1 → S_LOW; else dt_cnt++.
  - DEADTIME=0: S_LOW↔S_HIGH directly, DT states unused.
  - A raw pulse shorter than DEADTIME is swallowed: the opposite device never turns on.
- Fault:
  - fault passes through a 2-flop synchronizer (fs).
  - fs=1 sets fault_latched and forces S_IDLE on the next clock.
  - Worst-case shutdown is 3 clocks from fault rising.
  - fault_clr clears fault_latched only when fs=0; otherwise it is ignored.
  - After clear: remain in S_IDLE until the next sync, then S_LOW.
  - Fault set and clear in the same cycle: set wins.
- Invariant: pwm_h & pwm_l never 1 in any cycle, including reset, fault and en transitions.
- Width rule: dt_cnt sized clog2(DEADTIME+1), minimum 1 bit.

Test Plan:
- Nominal duty (PERIOD=100, DEADTIME=5, en=1, duty_in=50), checked after second sync:
  - sync every 200 clocks.
  - pwm_h high 94 clocks/period, pwm_l high 96.
  - Two 5-clock both-low windows per period.
- Clamp extremes (duty_in=-7): pwm_h always 0, pwm_l always 1.
- Clamp extremes (duty_in=250): pwm_h always 1 after entry, pwm_l 0.
- Valley-only update (duty_in 50→80 at carrier=30 counting up):
  - Current period still gives pwm_h 94 clocks.
  - Next period gives 154 clocks.
- Short pulse swallowed (duty_in=2, raw 3 clocks):
  - pwm_h never 1.
  - pwm_l low exactly 3 consecutive clocks per period.
  - Never both high.
- Fault sequence:
  - 1-clock fault pulse while pwm_h=1: both outputs 0 within 3 clocks, fault_latched=1.
  - fault_clr while fault held high: ignored.
  - fault released, then fault_clr: outputs stay 0 until next sync, then pwm_l=1 and normal modulation resumes.
- Async reset: rst pulled low mid-pwm_h-high, between clock edges → pwm_h, pwm_l, sync, fault_latched and carrier all 0 immediately, without waiting for a clock edge.
